// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter: round-robin share of one init_i2c AXI master between N_REQ config agents.
// Latency: req -> M_INIT_AXI_TXN 1 cycle; ack 1 cycle after accepted done edge or timeout expiry.
// Backpressure: requesters hold req until ack; `define I2C_ARB_RETRY_EN to retry M_ERROR completions.
module i2c_cfg_arbiter #(
    parameter int N_REQ          = 3,
    parameter int CMD_W          = 8,
    parameter int PULSE_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CMD_W-1:0] cmd,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   ack_err,
    output logic                   ack_timeout,
    output logic                   busy,
    output logic [15:0]            err_count,
    output logic                   M_INIT_AXI_TXN,
    output logic [CMD_W-1:0]       M_TXN_CMD,
    input  logic                   M_TXN_DONE,
    input  logic                   M_ERROR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PL_W  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PL_W-1:0]  pulse_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             done_q;
    logic             done_pend;
    logic             err_pend;

    logic             any_req;
    logic [N_REQ-1:0] win_oh;
    logic [PTR_W-1:0] next_ptr;
    logic [CMD_W-1:0] win_cmd;
    int               idx;
    int               nxt;

    // Walk offsets high-to-low so the lowest offset from rr_ptr is the last, winning, write.
    always_comb begin
        win_oh   = '0;
        next_ptr = '0;
        win_cmd  = '0;
        idx      = 0;
        nxt      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_cmd     = cmd[idx*CMD_W +: CMD_W];
                nxt         = idx + 1;
                if (nxt >= N_REQ) nxt = 0;
                next_ptr    = nxt[PTR_W-1:0];
            end
        end
    end

    assign any_req = |req;
    assign busy    = (state != S_IDLE);

    logic done_rise;
    logic done_evt;
    logic evt_err;
    logic to_hit;
    logic can_retry;

    // done_q follows the level in every state, so a done still high from the previous
    // transaction never looks like a fresh edge; edges during START are held in done_pend.
    assign done_rise = M_TXN_DONE & ~done_q;
    assign done_evt  = done_rise | done_pend;
    assign evt_err   = done_rise ? M_ERROR : err_pend;
    assign to_hit    = (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

`ifdef I2C_ARB_RETRY_EN
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RT_W-1:0] retry_cnt;

    assign can_retry = evt_err && (int'(retry_cnt) < MAX_RETRY);

    always_ff @(posedge ACLK) begin
        if (ARESET || state == S_IDLE) begin
            retry_cnt <= '0;
        end else if (state == S_WAIT && done_evt && can_retry) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    logic [31:0] max_retry_unused;

    assign can_retry        = 1'b0;
    assign max_retry_unused = MAX_RETRY;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            pulse_cnt      <= '0;
            to_cnt         <= '0;
            done_q         <= 1'b0;
            done_pend      <= 1'b0;
            err_pend       <= 1'b0;
            grant          <= '0;
            ack            <= '0;
            ack_err        <= 1'b0;
            ack_timeout    <= 1'b0;
            err_count      <= '0;
            M_INIT_AXI_TXN <= 1'b0;
            M_TXN_CMD      <= '0;
        end else begin
            done_q      <= M_TXN_DONE;
            ack         <= '0;
            ack_err     <= 1'b0;
            ack_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state          <= S_START;
                        grant          <= win_oh;
                        M_TXN_CMD      <= win_cmd;
                        rr_ptr         <= next_ptr;
                        M_INIT_AXI_TXN <= 1'b1;
                        pulse_cnt      <= '0;
                        to_cnt         <= '0;
                        done_pend      <= 1'b0;
                        err_pend       <= 1'b0;
                    end
                end
                S_START: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (done_rise) begin
                        done_pend <= 1'b1;
                        err_pend  <= M_ERROR;
                    end
                    if (pulse_cnt == PL_W'(PULSE_LEN - 1)) begin
                        state          <= S_WAIT;
                        M_INIT_AXI_TXN <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (done_evt) begin
                        done_pend <= 1'b0;
                        err_pend  <= 1'b0;
                        if (can_retry) begin
                            state          <= S_START;
                            M_INIT_AXI_TXN <= 1'b1;
                            pulse_cnt      <= '0;
                            to_cnt         <= '0;
                        end else begin
                            state   <= S_RESP;
                            ack     <= grant;
                            ack_err <= evt_err;
                        end
                    end else if (to_hit) begin
                        state       <= S_RESP;
                        ack         <= grant;
                        ack_err     <= 1'b1;
                        ack_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    grant <= '0;
                    if (ack_err && err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Randomized bench for i2c_cfg_arbiter: a transaction-level schedule model predicts grant, pulse,
// ack timing and flags per cycle; a scripted master drives done/error from the same schedule.
module tb_i2c_cfg_arbiter;

    localparam int N    = 3;
    localparam int CW   = 8;
    localparam int PL   = 2;
    localparam int TO   = 50;
    localparam int MR   = 3;
    localparam int NCYC = 4000;
`ifdef I2C_ARB_RETRY_EN
    localparam int RETRIES = MR;
`else
    localparam int RETRIES = 0;
`endif

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] cmd = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            ack_err;
    logic            ack_timeout;
    logic            busy;
    logic [15:0]     err_count;
    logic            M_INIT_AXI_TXN;
    logic [CW-1:0]   M_TXN_CMD;
    logic            M_TXN_DONE = 1'b0;
    logic            M_ERROR = 1'b0;

    always #5 ACLK = ~ACLK;

    i2c_cfg_arbiter #(
        .N_REQ(N), .CMD_W(CW), .PULSE_LEN(PL), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req(req), .cmd(cmd), .grant(grant), .ack(ack),
        .ack_err(ack_err), .ack_timeout(ack_timeout), .busy(busy), .err_count(err_count),
        .M_INIT_AXI_TXN(M_INIT_AXI_TXN), .M_TXN_CMD(M_TXN_CMD),
        .M_TXN_DONE(M_TXN_DONE), .M_ERROR(M_ERROR)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model of the arbiter at transaction level
    int            m_ptr = 0;
    bit            m_active = 0;
    bit            m_fresh = 1;
    int            m_win = 0;
    logic [CW-1:0] m_cmd = '0;
    int            m_p0 = 0;
    int            m_resp = -1;
    int            m_idle_from = 0;
    bit            m_err = 0;
    bit            m_to = 0;
    int            m_errcnt = 0;
    int            pulse_q[$];

    // Scripted master: level changes at absolute cycles
    int            ev_cyc[$];
    bit            ev_done[$];
    bit            ev_err[$];

    bit            r_req[N];
    logic [CW-1:0] r_cmd[N];

    task automatic push_ev(input int c, input bit d, input bit e);
        ev_cyc.push_back(c);
        ev_done.push_back(d);
        ev_err.push_back(e);
    endtask

    // Decide the master's response for every attempt up front and derive ack cycle and flags.
    task automatic plan_txn(input int p0);
        int p, tries, drop, kind, x, a;
        bit e;
        p = p0;
        tries = 0;
        pulse_q.delete();
        forever begin
            pulse_q.push_back(p);
            drop = $urandom_range(0, 2);
            push_ev(p + drop, 1'b0, 1'b0);
            kind = $urandom_range(0, 19);
            e = ($urandom_range(0, 2) == 0);
            if (kind < 16)       x = p + drop + 1 + $urandom_range(0, 12);
            else if (kind == 16) x = p + TO - 1;
            else if (kind == 17) x = p + TO;
            else                 x = -1;
            if (x >= 0) push_ev(x, 1'b1, e);
            if (x >= 0 && x <= p + TO - 1) begin
                a = (x > p + PL) ? x : p + PL;
                if (e && tries < RETRIES) begin
                    tries++;
                    p = a + 1;
                end else begin
                    m_resp = a + 1;
                    m_err  = e;
                    m_to   = 1'b0;
                    break;
                end
            end else begin
                m_resp = p + TO;
                m_err  = 1'b1;
                m_to   = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit            rst_now;
        bit            forced_done;
        bit            in_txn;
        bit            exp_pulse;
        int            ack_who;
        logic [N-1:0]  exp_oh;
        logic [N-1:0]  exp_grant;
        logic [N-1:0]  exp_ack;

        forced_done = 0;
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0;
            r_cmd[i] = '0;
        end

        for (int n = 0; n < NCYC; n++) begin
            @(negedge ACLK);
            cyc = n;

            // Outputs of cycle n against the model
            in_txn = m_active && n >= m_p0 && n <= m_resp;
            exp_oh = '0;
            exp_oh[m_win] = 1'b1;
            exp_grant = in_txn ? exp_oh : '0;
            exp_ack   = (m_active && n == m_resp) ? exp_oh : '0;
            exp_pulse = 1'b0;
            if (m_active) begin
                foreach (pulse_q[k]) begin
                    if (n >= pulse_q[k] && n <= pulse_q[k] + PL - 1) exp_pulse = 1'b1;
                end
            end
            check_val("grant", 32'(grant), 32'(exp_grant));
            check_val("pulse", 32'(M_INIT_AXI_TXN), 32'(exp_pulse));
            check_val("busy", 32'(busy), 32'(in_txn));
            check_val("ack", 32'(ack), 32'(exp_ack));
            check_val("err_count", 32'(err_count), 32'(m_errcnt));
            if (in_txn) check_val("txn_cmd", 32'(M_TXN_CMD), 32'(m_cmd));
            else if (m_fresh) check_val("txn_cmd_rst", 32'(M_TXN_CMD), 32'd0);
            if (m_active && n == m_resp) begin
                check_val("ack_err", 32'(ack_err), 32'(m_err));
                check_val("ack_timeout", 32'(ack_timeout), 32'(m_to));
            end

            ack_who = -1;
            if (m_active && n == m_resp) begin
                ack_who = m_win;
                if (m_err && m_errcnt < 16'hFFFF) m_errcnt++;
                m_active = 1'b0;
                m_idle_from = n + 1;
            end

            // Reset: a few cycles at start, one forced mid-WAIT, and rare random ones
            rst_now = (n < 3) || ($urandom_range(0, 699) == 0);
            if (!forced_done && n >= 1500 && m_active && pulse_q.size() > 0 &&
                n >= pulse_q[$] + PL && n < m_resp) begin
                rst_now = 1'b1;
                forced_done = 1'b1;
            end

            // Requesters
            for (int i = 0; i < N; i++) begin
                if (i == ack_who) begin
                    r_req[i] = ($urandom_range(0, 2) == 0);
                    if (r_req[i]) r_cmd[i] = CW'($urandom);
                end else if (m_active && m_win == i) begin
                    if ($urandom_range(0, 24) == 0) r_req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) r_cmd[i] = CW'($urandom);
                end else if (!r_req[i] && $urandom_range(0, 3) == 0) begin
                    r_req[i] = 1'b1;
                    r_cmd[i] = CW'($urandom);
                end
            end

            // Round-robin arbitration in an IDLE cycle
            if (!rst_now && !m_active && n >= m_idle_from) begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (!m_active && r_req[w]) begin
                        m_active = 1'b1;
                        m_win    = w;
                        m_cmd    = r_cmd[w];
                        m_ptr    = (w + 1) % N;
                        m_p0     = n + 1;
                        m_fresh  = 1'b0;
                        plan_txn(n + 1);
                    end
                end
            end

            while (ev_cyc.size() > 0 && ev_cyc[0] <= n) begin
                M_TXN_DONE = ev_done[0];
                if (ev_done[0]) M_ERROR = ev_err[0];
                void'(ev_cyc.pop_front());
                void'(ev_done.pop_front());
                void'(ev_err.pop_front());
            end

            if (rst_now) begin
                m_active    = 1'b0;
                m_ptr       = 0;
                m_errcnt    = 0;
                m_fresh     = 1'b1;
                m_idle_from = n + 1;
                pulse_q.delete();
                ev_cyc.delete();
                ev_done.delete();
                ev_err.delete();
            end

            ARESET = rst_now;
            for (int i = 0; i < N; i++) begin
                req[i] = r_req[i];
                cmd[i*CW +: CW] = r_cmd[i];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
